// File: rtl/fifo_top.sv
// Register-controlled FWFT FIFO: push/pop commit on the qualifying edge, registers read combinationally.
// Backpressure via w_ready/r_enable; sticky OVERFLOW/UNDERFLOW status under FIFO_TOP_ERR_STATUS_EN.
module fifo_top #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [DATA_W-1:0] reg_wdata,
  input  logic              reg_wen,
  input  logic              reg_ren,
  output logic [DATA_W-1:0] reg_rdata,
  output logic              reg_ready,
  input  logic              sel,
  input  logic              is_write,
  input  logic              w_enable,
  input  logic [WIDTH-1:0]  w_data,
  output logic              w_ready,
  output logic              r_enable,
  output logic [WIDTH-1:0]  r_data,
  input  logic              r_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL   = ADDR_W'('h00);
  localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'('h04);
  localparam logic [ADDR_W-1:0] ADDR_THRESH = ADDR_W'('h08);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  thresh;
  logic              enable;
  logic              empty, full, almost_full;
  logic              ctrl_wr, thresh_wr, clear;
  logic              push, pop;
  logic [DATA_W-1:0] status;
  logic              unused_ok;

  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign almost_full = (count >= thresh);

  assign ctrl_wr   = reg_wen && (reg_addr == ADDR_CTRL);
  assign thresh_wr = reg_wen && (reg_addr == ADDR_THRESH);
  assign clear     = ctrl_wr && reg_wdata[1];

  assign w_ready  = enable && !full;
  assign r_enable = enable && !empty;
  assign push     = sel && is_write && w_enable && w_ready;
  assign pop      = sel && !is_write && r_ready && r_enable;

  assign r_data    = empty ? '0 : mem[rd_ptr];
  assign reg_ready = 1'b1;
  assign unused_ok = ^reg_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable <= 1'b0;
      thresh <= CNT_W'(DEPTH - 1);
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (ctrl_wr)   enable <= reg_wdata[0];
      if (thresh_wr) thresh <= reg_wdata[CNT_W-1:0];
      // A flush wins over any push/pop on the same edge.
      if (clear) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        count  <= count + CNT_W'(1);
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        count  <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= w_data;
  end

`ifdef FIFO_TOP_ERR_STATUS_EN
  logic overflow, underflow;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (sel && is_write && w_enable && enable && full)  overflow  <= 1'b1;
      if (sel && !is_write && r_ready && enable && empty) underflow <= 1'b1;
    end
  end
`endif

  always_comb begin
    status              = '0;
    status[0]           = empty;
    status[1]           = full;
    status[2]           = almost_full;
    status[8 +: CNT_W]  = count;
`ifdef FIFO_TOP_ERR_STATUS_EN
    status[3]           = overflow;
    status[4]           = underflow;
`endif
  end

  // Pure read path: a simultaneous write is seen only after the edge.
  always_comb begin
    reg_rdata = '0;
    if (reg_ren) begin
      case (reg_addr)
        ADDR_CTRL:   reg_rdata = DATA_W'(enable);
        ADDR_STATUS: reg_rdata = status;
        ADDR_THRESH: reg_rdata = DATA_W'(thresh);
        default:     reg_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_top.sv
// Directed self-checking bench for fifo_top (DEPTH=16, WIDTH=8).
module tb_fifo_top;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic        reg_wen, reg_ren;
  logic [31:0] reg_rdata;
  logic        reg_ready;
  logic        sel, is_write, w_enable, w_ready, r_enable, r_ready;
  logic [7:0]  w_data, r_data;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FIFO_TOP_ERR_STATUS_EN
  localparam logic [31:0] OVF = 32'h8;
  localparam logic [31:0] UDF = 32'h10;
`else
  localparam logic [31:0] OVF = 32'h0;
  localparam logic [31:0] UDF = 32'h0;
`endif

  fifo_top dut (
    .clk(clk), .rst_n(rst_n),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wen(reg_wen), .reg_ren(reg_ren),
    .reg_rdata(reg_rdata), .reg_ready(reg_ready),
    .sel(sel), .is_write(is_write), .w_enable(w_enable), .w_data(w_data),
    .w_ready(w_ready), .r_enable(r_enable), .r_data(r_data), .r_ready(r_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    reg_addr = a; reg_wdata = d; reg_wen = 1'b1;
    @(negedge clk);
    reg_wen = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    @(negedge clk);
    reg_addr = a; reg_ren = 1'b1;
    #1 chk(tag, reg_rdata, exp);
    reg_ren = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    @(negedge clk);
    sel = 1'b1; is_write = 1'b1; w_enable = 1'b1; w_data = d;
    @(negedge clk);
    sel = 1'b0; w_enable = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    @(negedge clk);
    sel = 1'b1; is_write = 1'b0; r_ready = 1'b1;
    #1;
    chk({tag, "_vld"}, {31'd0, r_enable}, 32'd1);
    chk(tag, {24'd0, r_data}, {24'd0, exp});
    @(negedge clk);
    sel = 1'b0; r_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; reg_addr = '0; reg_wdata = '0; reg_wen = 1'b0; reg_ren = 1'b0;
    sel = 1'b0; is_write = 1'b0; w_enable = 1'b0; w_data = '0; r_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    #1;
    chk("rst_w_ready",   {31'd0, w_ready},   32'd0);
    chk("rst_r_enable",  {31'd0, r_enable},  32'd0);
    chk("rst_r_data",    {24'd0, r_data},    32'd0);
    chk("rst_reg_ready", {31'd0, reg_ready}, 32'd1);
    chk("rst_rdata_idle", reg_rdata,         32'd0);
    reg_chk("rst_ctrl",   8'h00, 32'h0);
    reg_chk("rst_status", 8'h04, 32'h1);
    reg_chk("rst_thresh", 8'h08, 32'hF);
    reg_chk("unmapped",   8'h0C, 32'h0);

    reg_wr(8'h00, 32'h1);
    reg_chk("ctrl_en", 8'h00, 32'h1);
    reg_wr(8'h08, 32'hA);
    reg_chk("thresh_a", 8'h08, 32'hA);
    reg_wr(8'h04, 32'hFFFF_FFFF);
    reg_chk("status_ro", 8'h04, 32'h1);

    // Basic ordering
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    reg_chk("status_5", 8'h04, 32'h500);
    for (int i = 0; i < 5; i++) pop_chk($sformatf("pop_a%0d", i), 8'hA0 + 8'(i));
    reg_chk("status_empty", 8'h04, 32'h1);

    // Flush
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    reg_chk("status_8", 8'h04, 32'h800);
    reg_wr(8'h00, 32'h3);
    reg_chk("ctrl_after_clr", 8'h00, 32'h1);
    reg_chk("status_clr", 8'h04, 32'h1);
    #1 chk("clr_r_enable", {31'd0, r_enable}, 32'd0);
    chk("clr_r_data", {24'd0, r_data}, 32'd0);

    // Almost-full threshold
    reg_wr(8'h08, 32'h4);
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
    reg_chk("af_3", 8'h04, 32'h300);
    push(8'h33);
    reg_chk("af_4", 8'h04, 32'h404);
    reg_wr(8'h00, 32'h3);

    // Read during write returns old value
    @(negedge clk);
    reg_addr = 8'h08; reg_wdata = 32'h7; reg_wen = 1'b1; reg_ren = 1'b1;
    #1 chk("rw_old", reg_rdata, 32'h4);
    @(negedge clk);
    reg_wen = 1'b0; reg_ren = 1'b0;
    reg_chk("rw_new", 8'h08, 32'h7);
    reg_wr(8'h08, 32'h4);

    // Disabled: pushes ignored
    reg_wr(8'h00, 32'h0);
    @(negedge clk);
    sel = 1'b1; is_write = 1'b1; w_enable = 1'b1; w_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      #1 chk($sformatf("dis_w_ready%0d", i), {31'd0, w_ready}, 32'd0);
      @(negedge clk);
    end
    sel = 1'b0; w_enable = 1'b0;
    reg_chk("dis_status", 8'h04, 32'h1);
    reg_wr(8'h00, 32'h1);

    // Offset pointers so the full run wraps
    for (int i = 0; i < 3; i++) push(8'h50 + 8'(i));
    for (int i = 0; i < 3; i++) pop_chk($sformatf("pop_off%0d", i), 8'h50 + 8'(i));
    for (int i = 0; i < 16; i++) push(8'hC0 + 8'(i));
    reg_chk("full_status", 8'h04, 32'h1006);
    #1 chk("full_w_ready", {31'd0, w_ready}, 32'd0);
    push(8'hFF);
    reg_chk("overflow", 8'h04, 32'h1006 | OVF);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("pop_c%0d", i), 8'hC0 + 8'(i));
    reg_chk("drained", 8'h04, 32'h1 | OVF);
    @(negedge clk);
    sel = 1'b1; is_write = 1'b0; r_ready = 1'b1;
    @(negedge clk);
    sel = 1'b0; r_ready = 1'b0;
    reg_chk("underflow", 8'h04, 32'h1 | OVF | UDF);
    reg_wr(8'h00, 32'h3);
    reg_chk("err_clr", 8'h04, 32'h1);

    // Reset mid-operation
    push(8'h77);
    push(8'h78);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    reg_chk("mid_rst_status", 8'h04, 32'h1);
    reg_chk("mid_rst_ctrl",   8'h00, 32'h0);
    reg_chk("mid_rst_thresh", 8'h08, 32'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
